// File: rtl/sseg_display_scheduler.sv
// Two-client arbiter for a multiplexed 4-digit seven-segment display; grants change only at frame boundaries.
// Optional macro SSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module sseg_display_scheduler #(
   parameter int N_REFRESH    = 18,
   parameter int DWELL_FRAMES = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [1:0]  i_req,
   input  logic [15:0] i_val0,
   input  logic [15:0] i_val1,
   output logic [1:0]  o_gnt,
   output logic [3:0]  o_hex,
   output logic [3:0]  o_ldsel,
   output logic        o_blank
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G0   = 2'd1,
      ST_G1   = 2'd2
   } state_t;

   localparam logic [N_REFRESH-1:0] CNT_ONE   = N_REFRESH'(1);
   localparam logic [7:0]           DWELL_MIN = 8'(DWELL_FRAMES);

   logic [N_REFRESH-1:0] cnt_q;
   state_t               state_q, state_d;
   logic [7:0]           dwell_q, dwell_d;
   logic                 last_q, last_d;
   logic [15:0]          lat_q, lat_d;
   logic [1:0]           gnt_q, gnt_d;

   logic       fb;
   logic [1:0] idx;
   logic       dwell_ok;
   logic       lz_blank;

   assign fb       = &cnt_q;
   assign idx      = cnt_q[N_REFRESH-1 -: 2];
   assign dwell_ok = (dwell_q >= DWELL_MIN);

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      last_d  = last_q;
      lat_d   = lat_q;
      if (fb) begin
         case (state_q)
            ST_IDLE: begin
               case (i_req)
                  2'b01:   state_d = ST_G0;
                  2'b10:   state_d = ST_G1;
                  // Contention goes to whoever was not served most recently
                  2'b11:   state_d = last_q ? ST_G0 : ST_G1;
                  default: state_d = ST_IDLE;
               endcase
            end
            ST_G0: begin
               if (!i_req[0])
                  state_d = i_req[1] ? ST_G1 : ST_IDLE;
               else if (dwell_ok && i_req[1])
                  state_d = ST_G1;
            end
            ST_G1: begin
               if (!i_req[1])
                  state_d = i_req[0] ? ST_G0 : ST_IDLE;
               else if (dwell_ok && i_req[0])
                  state_d = ST_G0;
            end
            default: state_d = ST_IDLE;
         endcase

         if (state_d != state_q)
            dwell_d = 8'd0;
         else if (state_q != ST_IDLE && dwell_q != 8'hFF)
            dwell_d = dwell_q + 8'd1;

         // Latch the next owner's value once per frame so a frame never tears
         if (state_d == ST_G0) begin
            lat_d  = i_val0;
            last_d = 1'b0;
         end else if (state_d == ST_G1) begin
            lat_d  = i_val1;
            last_d = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_d = 2'b00;
      if (state_d == ST_G0)
         gnt_d = 2'b01;
      else if (state_d == ST_G1)
         gnt_d = 2'b10;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q   <= '0;
         state_q <= ST_IDLE;
         dwell_q <= 8'd0;
         last_q  <= 1'b1;
         lat_q   <= 16'h0000;
         gnt_q   <= 2'b00;
      end else begin
         cnt_q   <= cnt_q + CNT_ONE;
         state_q <= state_d;
         dwell_q <= dwell_d;
         last_q  <= last_d;
         lat_q   <= lat_d;
         gnt_q   <= gnt_d;
      end
   end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
   always_comb begin
      lz_blank = 1'b0;
      case (idx)
         2'd3:    lz_blank = (lat_q[15:12] == 4'h0);
         2'd2:    lz_blank = (lat_q[15:8]  == 8'h00);
         2'd1:    lz_blank = (lat_q[15:4]  == 12'h000);
         default: lz_blank = 1'b0;
      endcase
   end
`else
   assign lz_blank = 1'b0;
`endif

   assign o_gnt   = gnt_q;
   assign o_ldsel = ~(4'b0001 << idx);
   assign o_hex   = lat_q[{idx, 2'b00} +: 4];
   assign o_blank = (state_q == ST_IDLE) | lz_blank;

endmodule

// File: tb/tb_sseg_display_scheduler.sv
// Randomised and directed bench for sseg_display_scheduler against a frame-level reference model.
module tb_sseg_display_scheduler;

   localparam int NR    = 4;
   localparam int DW    = 2;
   localparam int FRAME = 16;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [1:0]  i_req = 2'b00;
   logic [15:0] i_val0 = 16'h0;
   logic [15:0] i_val1 = 16'h0;
   logic [1:0]  o_gnt;
   logic [3:0]  o_hex;
   logic [3:0]  o_ldsel;
   logic        o_blank;

   int checks = 0;
   int failures = 0;

   // Reference model: cycle position, owner (0 idle, 1 client0, 2 client1), dwell, last served, shown value
   int          m_cnt, m_st, m_dw, m_last;
   logic [15:0] m_lat;

   always #5 clk = ~clk;

   sseg_display_scheduler #(.N_REFRESH(NR), .DWELL_FRAMES(DW)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_val0(i_val0), .i_val1(i_val1),
      .o_gnt(o_gnt), .o_hex(o_hex), .o_ldsel(o_ldsel), .o_blank(o_blank)
   );

   function automatic logic [10:0] exp_vec();
      int idx;
      logic [1:0] g;
      logic [3:0] ld, hx;
      logic [15:0] sh;
      logic bl;
      idx = m_cnt / 4;
      g   = (m_st == 0) ? 2'b00 : ((m_st == 1) ? 2'b01 : 2'b10);
      ld  = 4'hF ^ (4'h1 << idx);
      sh  = m_lat >> (4 * idx);
      hx  = sh[3:0];
      bl  = (m_st == 0);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      if (idx > 0 && sh == 16'h0) bl = 1'b1;
`endif
      return {g, ld, hx, bl};
   endfunction

   function automatic logic [10:0] dut_vec();
      return {o_gnt, o_ldsel, o_hex, o_blank};
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_st = 0; m_dw = 0; m_last = 1; m_lat = 16'h0;
   endtask

   task automatic model_edge();
      int nxt, k, o;
      logic [1:0] r;
      r = i_req;
      if (m_cnt == FRAME - 1) begin
         nxt = m_st;
         if (m_st == 0) begin
            if (r == 2'b00) nxt = 0;
            else if (r == 2'b01) nxt = 1;
            else if (r == 2'b10) nxt = 2;
            else nxt = (m_last == 0) ? 2 : 1;
         end else begin
            k = m_st - 1;
            o = 1 - k;
            if (!r[k]) nxt = r[o] ? o + 1 : 0;
            else if (m_dw >= DW && r[o]) nxt = o + 1;
         end
         if (nxt != m_st) begin
            m_dw = 0;
            if (nxt != 0) m_last = nxt - 1;
            $display("t=%0t grant change: owner %0d -> %0d", $time, m_st, nxt);
         end else if (m_st != 0 && m_dw < 255) begin
            m_dw = m_dw + 1;
         end
         if (nxt == 1) m_lat = i_val0;
         else if (nxt == 2) m_lat = i_val1;
         m_st = nxt;
      end
      m_cnt = (m_cnt + 1) % FRAME;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      i_req   = 2'b00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      i_reset = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      i_reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dut_vec() !== {2'b00, 4'b1110, 4'h0, 1'b1}) begin
         failures++;
         $display("FAIL reset_outputs: got=%b required=%b", dut_vec(), {2'b00, 4'b1110, 4'h0, 1'b1});
      end
      i_reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_run: cyc=%0d got=%b required=%b", i, dut_vec(), exp_vec());
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_scan();
      logic [3:0] digs[4];
      logic [3:0] lds[4];
      digs = '{4'h4, 4'h3, 4'h2, 4'h1};
      lds  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      do_reset();
      i_req  = 2'b01;
      i_val0 = 16'h1234;
      for (int i = 0; i < 32; i++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL scan_model: cyc=%0d got=%b required=%b", i, dut_vec(), exp_vec());
         end
         if (i == 14) begin
            checks++;
            if (o_gnt !== 2'b00) begin
               failures++;
               $display("FAIL scan_latency: gnt=%b required=00 before boundary", o_gnt);
            end
         end
         if (i >= 15 && i < 31) begin
            checks++;
            if ({o_gnt, o_hex, o_ldsel} !== {2'b01, digs[(i-15)/4], lds[(i-15)/4]}) begin
               failures++;
               $display("FAIL scan_digit: cyc=%0d got gnt=%b hex=%h ldsel=%b required gnt=01 hex=%h ldsel=%b",
                        i, o_gnt, o_hex, o_ldsel, digs[(i-15)/4], lds[(i-15)/4]);
            end
         end
      end
      $display("test_scan done");
   endtask

   task automatic test_dwell_rotation();
      bit saw_g1, saw_back;
      saw_g1 = 0; saw_back = 0;
      do_reset();
      i_req  = 2'b11;
      i_val0 = 16'($urandom);
      i_val1 = 16'($urandom);
      for (int i = 0; i < FRAME * 12; i++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL dwell_model: cyc=%0d got=%b required=%b", i, dut_vec(), exp_vec());
         end
         if (i == FRAME - 1) begin
            checks++;
            if (o_gnt !== 2'b01) begin
               failures++;
               $display("FAIL dwell_first: gnt=%b required=01", o_gnt);
            end
         end
         if (o_gnt == 2'b10) saw_g1 = 1;
         if (saw_g1 && o_gnt == 2'b01) saw_back = 1;
      end
      checks++;
      if (!(saw_g1 && saw_back)) begin
         failures++;
         $display("FAIL dwell_rotation: saw_g1=%0d saw_back=%0d required 1 1", saw_g1, saw_back);
      end
      $display("test_dwell_rotation done");
   endtask

   task automatic test_no_tearing();
      logic [15:0] word, sh;
      int c;
      do_reset();
      i_req  = 2'b01;
      i_val0 = 16'h00AB;
      repeat (FRAME + 6) tick();
      i_val0 = 16'h00CD;
      for (int i = 0; i < 26; i++) begin
         tick();
         c    = (7 + i) % FRAME;
         word = (i < 9) ? 16'h00AB : 16'h00CD;
         sh   = word >> (4 * (c / 4));
         checks++;
         if (o_hex !== sh[3:0] || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL no_tearing: cyc=%0d hex=%h required=%h vec=%b model=%b",
                     i, o_hex, sh[3:0], dut_vec(), exp_vec());
         end
      end
      $display("test_no_tearing done");
   endtask

   task automatic test_idle_handover();
      do_reset();
      i_req  = 2'b10;
      i_val1 = 16'($urandom);
      i_val0 = 16'($urandom);
      repeat (FRAME + 8) tick();
      i_req = 2'b00;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL idle_model: cyc=%0d got=%b required=%b", i, dut_vec(), exp_vec());
         end
      end
      checks++;
      if (o_gnt !== 2'b00 || o_blank !== 1'b1) begin
         failures++;
         $display("FAIL idle_entry: gnt=%b blank=%b required gnt=00 blank=1", o_gnt, o_blank);
      end
      i_req = 2'b10;
      repeat (FRAME + 4) tick();
      i_req = 2'b01;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL handover_model: cyc=%0d got=%b required=%b", i, dut_vec(), exp_vec());
         end
      end
      checks++;
      if (o_gnt !== 2'b01) begin
         failures++;
         $display("FAIL handover_direct: gnt=%b required=01", o_gnt);
      end
      $display("test_idle_handover done");
   endtask

   task automatic test_async_reset();
      do_reset();
      i_req  = 2'b10;
      i_val1 = 16'hBEEF;
      repeat (FRAME + 5) tick();
      #2;
      i_reset = 1'b1;
      #1;
      checks++;
      if (dut_vec() !== {2'b00, 4'b1110, 4'h0, 1'b1}) begin
         failures++;
         $display("FAIL async_reset: got=%b required=%b", dut_vec(), {2'b00, 4'b1110, 4'h0, 1'b1});
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      i_reset = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL post_reset_model: cyc=%0d got=%b required=%b", i, dut_vec(), exp_vec());
         end
         if (i == FRAME - 2) begin
            checks++;
            if (o_gnt !== 2'b00 || o_hex !== 4'h0) begin
               failures++;
               $display("FAIL post_reset_idle: gnt=%b hex=%h required gnt=00 hex=0", o_gnt, o_hex);
            end
         end
      end
      checks++;
      if (o_gnt !== 2'b10) begin
         failures++;
         $display("FAIL post_reset_grant: gnt=%b required=10", o_gnt);
      end
      $display("test_async_reset done");
   endtask

   task automatic test_dwell_saturate();
      do_reset();
      i_req  = 2'b01;
      i_val0 = 16'($urandom);
      i_val1 = 16'($urandom);
      for (int i = 0; i < FRAME * 257; i++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL sat_model: cyc=%0d got=%b required=%b", i, dut_vec(), exp_vec());
         end
      end
      i_req = 2'b11;
      repeat (FRAME) tick();
      checks++;
      if (o_gnt !== 2'b10) begin
         failures++;
         $display("FAIL sat_switch: gnt=%b required=10", o_gnt);
      end
      $display("test_dwell_saturate done");
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < FRAME * 60; i++) begin
         if ($urandom_range(0, 9) == 0) i_req = 2'($urandom);
         if ($urandom_range(0, 5) == 0) i_val0 = 16'($urandom);
         if ($urandom_range(0, 5) == 0) i_val1 = 16'($urandom);
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random: cyc=%0d got=%b required=%b", i, dut_vec(), exp_vec());
         end
      end
      $display("test_random done");
   endtask

`ifdef SSEG_LEADING_ZERO_BLANK_EN
   task automatic test_leading_zero();
      logic [3:0] want0, want1;
      do_reset();
      i_req  = 2'b01;
      i_val0 = 16'h0050;
      repeat (FRAME) tick();
      want0 = 4'b1100;
      for (int i = 0; i < FRAME; i++) begin
         checks++;
         if (o_blank !== want0[m_cnt/4]) begin
            failures++;
            $display("FAIL lz_0050: cnt=%0d blank=%b required=%b", m_cnt, o_blank, want0[m_cnt/4]);
         end
         if (i == FRAME - 2) i_val0 = 16'h0000;
         tick();
      end
      want1 = 4'b1110;
      for (int i = 0; i < FRAME; i++) begin
         checks++;
         if (o_blank !== want1[m_cnt/4] || o_hex !== 4'h0) begin
            failures++;
            $display("FAIL lz_0000: cnt=%0d blank=%b hex=%h required blank=%b hex=0",
                     m_cnt, o_blank, o_hex, want1[m_cnt/4]);
         end
         tick();
      end
      $display("test_leading_zero done");
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_scan();
      test_dwell_rotation();
      test_no_tearing();
      test_idle_handover();
      test_async_reset();
      test_dwell_saturate();
      test_random();
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      test_leading_zero();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
